// File: rtl/mem_access_controller_pkg.sv
// Shared definitions for the byte-serial memory access controller:
// data width, access-size encodings, FSM state encoding and request legality.
package mem_access_controller_pkg;

    localparam int DATA_WIDTH = 32;

    // Access size as presented on memLength; 2'd2 is not a legal size.
    typedef enum logic [1:0] {
        LEN_BYTE = 2'd0,
        LEN_HALF = 2'd1,
        LEN_WORD = 2'd3
    } mem_len_e;

    localparam logic [1:0] LEN_ILLEGAL = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    // A request is rejected when it is neither a pure load nor a pure store,
    // uses the reserved size code, or is not naturally aligned.
    function automatic logic is_illegal(input logic       load,
                                        input logic       store,
                                        input logic [1:0] mem_length,
                                        input logic [1:0] addr_lo);
        return (load == store)
            || (mem_length == LEN_ILLEGAL)
            || ((mem_length == LEN_HALF) && addr_lo[0])
            || ((mem_length == LEN_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_controller_if.sv
// Byte-wide memory port between the access controller (master) and memory (slave).
interface mem_access_controller_if;
    import mem_access_controller_pkg::*;

    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;
    logic                  mem_ack;
    logic [7:0]            mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/mem_access_controller_load_extender.sv
// Sign/zero extension of an assembled little-endian load word to full width.
module load_extender
    import mem_access_controller_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] raw_i,
    input  logic [1:0]            mem_length_i,
    input  logic                  load_unsigned_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    // Extend from bit 7 for bytes and bit 15 for halves; words pass through.
    always_comb begin
        // NOTE: default assignment first so every path drives data_o and no latch is inferred.
        data_o = raw_i;
        case (mem_length_i)
            LEN_BYTE: data_o = {{(DATA_WIDTH-8){~load_unsigned_i & raw_i[7]}}, raw_i[7:0]};
            LEN_HALF: data_o = {{(DATA_WIDTH-16){~load_unsigned_i & raw_i[15]}}, raw_i[15:0]};
            default:  data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/mem_access_controller.sv
// Memory access controller: splits a byte/half/word load or store into
// sequential byte transactions on a req/ack memory port and assembles loads.
module mem_access_controller
    import mem_access_controller_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   load,
    input  logic                   store,
    input  logic                   loadUnsigned,
    input  logic [1:0]             memLength,
    input  logic [DATA_WIDTH-1:0]  address,
    input  logic [DATA_WIDTH-1:0]  storeData,
    mem_access_controller_if.master mem,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [DATA_WIDTH-1:0]  loadData
);

    state_e                state_q;
    logic [1:0]            idx_q;       // byte index within the access
    logic [1:0]            len_q;       // latched size code, equal to the last byte index
    logic                  load_q;
    logic                  uns_q;
    logic                  req_q;
    logic                  we_q;
    logic                  done_q;
    logic                  error_q;
    logic [DATA_WIDTH-1:0] addr_q;      // address of the byte currently on the bus
    logic [DATA_WIDTH-1:0] wdata_q;     // store data, shifted so the current byte is lowest
    logic [DATA_WIDTH-1:0] rdata_q;     // load bytes captured so far
    logic [DATA_WIDTH-1:0] load_data_q;
    logic [DATA_WIDTH-1:0] raw_word_d;
    logic [DATA_WIDTH-1:0] ext_data;

    // Merge the byte arriving this cycle into its little-endian lane.
    always_comb begin
        raw_word_d = rdata_q;
        raw_word_d[{idx_q, 3'b000} +: 8] = mem.mem_rdata;
    end

    load_extender u_load_extender (
        .raw_i           (raw_word_d),
        .mem_length_i    (len_q),
        .load_unsigned_i (uns_q),
        .data_o          (ext_data)
    );

    // Access sequencer: accept/reject in IDLE, step bytes on ack, pulse done for one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            idx_q       <= 2'd0;
            len_q       <= 2'd0;
            load_q      <= 1'b0;
            uns_q       <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            // NOTE: the capture register is reset so an aborted load leaves no partial bytes behind.
            rdata_q     <= '0;
            load_data_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (is_illegal(load, store, memLength, address[1:0])) begin
                            state_q <= S_ERR;
                            done_q  <= 1'b1;
                            error_q <= 1'b1;
                        end else begin
                            state_q <= S_XFER;
                            req_q   <= 1'b1;
                            we_q    <= store;
                            addr_q  <= address;
                            wdata_q <= storeData;
                            rdata_q <= '0;
                            idx_q   <= 2'd0;
                            len_q   <= memLength;
                            load_q  <= load;
                            uns_q   <= loadUnsigned;
                        end
                    end
                end
                S_XFER: begin
                    if (mem.mem_ack) begin
                        rdata_q <= raw_word_d;
                        if (idx_q == len_q) begin
                            state_q <= S_DONE;
                            req_q   <= 1'b0;
                            we_q    <= 1'b0;
                            done_q  <= 1'b1;
                            if (load_q) begin
                                load_data_q <= ext_data;
                            end
                        end else begin
                            idx_q   <= idx_q + 2'd1;
                            addr_q  <= addr_q + DATA_WIDTH'(1);
                            wdata_q <= wdata_q >> 8;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q[7:0];
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign error         = error_q;
    assign loadData      = load_data_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// Self-checking bench for mem_access_controller: directed scenarios plus a
// randomized sweep against a byte-array memory model.
module tb_mem_access_controller;
    import mem_access_controller_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  data;
    } txn_t;

    typedef struct {
        logic        ld;
        logic        st;
        logic [1:0]  len;
        logic [31:0] a;
        string       name;
    } err_case_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        load = 1'b0;
    logic        store = 1'b0;
    logic        loadUnsigned = 1'b0;
    logic [1:0]  memLength = 2'd0;
    logic [31:0] address = '0;
    logic [31:0] storeData = '0;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] loadData;

    mem_access_controller_if mif();

    mem_access_controller dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .load         (load),
        .store        (store),
        .loadUnsigned (loadUnsigned),
        .memLength    (memLength),
        .address      (address),
        .storeData    (storeData),
        .mem          (mif),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .loadData     (loadData)
    );

    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_total = 0;
    logic [7:0]  mem_model [0:255];
    txn_t        acc_log[$];
    int          ack_delay = 0;
    bit          rand_delay = 1'b0;
    bit          stray_ack = 1'b0;
    logic [31:0] exp_ld = '0;

    int          r_lat;
    int          r_done;
    int          r_err;
    int          r_err_cd;
    int          r_req;
    logic [31:0] r_ld_at_done;

    // Reference load result straight from the memory model and the extension rules.
    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] len, input bit uns);
        int     n;
        longint v;
        n = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
        v = 0;
        for (int k = 0; k < n; k++)
            v += longint'(mem_model[8'(a + 32'(k))]) * (longint'(1) << (8 * k));
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v -= (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    // Memory responder: acks after a programmable wait, checks the bus holds while waiting.
    initial begin : responder
        bit          holding;
        int          waited;
        int          cur_delay;
        logic [31:0] h_addr;
        logic        h_we;
        logic [7:0]  h_wdata;
        txn_t        t;
        holding = 1'b0; waited = 0; cur_delay = 0;
        h_addr = '0; h_we = 1'b0; h_wdata = '0;
        mif.mem_ack = 1'b0;
        mif.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mif.mem_ack = 1'b0;
            mif.mem_rdata = 8'($urandom);
            if (mif.mem_req !== 1'b1) begin
                holding = 1'b0;
                if (stray_ack) mif.mem_ack = 1'b1;
            end else begin
                if (!holding) begin
                    holding = 1'b1;
                    waited = 0;
                    cur_delay = rand_delay ? int'($urandom_range(0, 2)) : ack_delay;
                    h_addr = mif.mem_addr; h_we = mif.mem_we; h_wdata = mif.mem_wdata;
                end else begin
                    n_total++;
                    if ({mif.mem_addr, mif.mem_we, mif.mem_wdata} !== {h_addr, h_we, h_wdata})
                        $display("FAIL hold_stable: bus addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                                 mif.mem_addr, mif.mem_we, mif.mem_wdata, h_addr, h_we, h_wdata);
                    else
                        n_pass++;
                end
                if (waited == cur_delay) begin
                    mif.mem_ack = 1'b1;
                    holding = 1'b0;
                    if (mif.mem_we) mem_model[mif.mem_addr[7:0]] = mif.mem_wdata;
                    else mif.mem_rdata = mem_model[mif.mem_addr[7:0]];
                    t.addr = mif.mem_addr;
                    t.we   = mif.mem_we;
                    t.data = mif.mem_we ? mif.mem_wdata : mif.mem_rdata;
                    acc_log.push_back(t);
                end else begin
                    waited++;
                end
            end
        end
    end

    // Issue one request and observe max_cyc cycles; cycle 1 is the cycle after start is sampled.
    task automatic run_access(input logic ld, input logic st, input logic uns, input logic [1:0] len,
                              input logic [31:0] a, input logic [31:0] sd, input int max_cyc,
                              input int extra_start);
        @(posedge clk);
        #2;
        acc_log.delete();
        load = ld; store = st; loadUnsigned = uns; memLength = len; address = a; storeData = sd;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        r_lat = 0; r_done = 0; r_err = 0; r_err_cd = 0; r_req = 0; r_ld_at_done = 'x;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (mif.mem_req === 1'b1) r_req++;
            if (done === 1'b1) begin
                r_done++;
                if (r_lat == 0) begin
                    r_lat = c;
                    r_ld_at_done = loadData;
                end
            end
            if (error === 1'b1) r_err++;
            if (error === 1'b1 && done === 1'b1) r_err_cd++;
            start = (c == extra_start);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({busy, done, error, mif.mem_req, mif.mem_we} !== 5'b0)
            $display("FAIL reset_flags: busy/done/error/req/we=%b, required 00000",
                     {busy, done, error, mif.mem_req, mif.mem_we});
        else n_pass++;
        n_total++;
        if (mif.mem_addr !== 32'h0) $display("FAIL reset_addr: got %h, required 0", mif.mem_addr);
        else n_pass++;
        n_total++;
        if (mif.mem_wdata !== 8'h0) $display("FAIL reset_wdata: got %h, required 0", mif.mem_wdata);
        else n_pass++;
        n_total++;
        if (loadData !== 32'h0) $display("FAIL reset_loaddata: got %h, required 0", loadData);
        else n_pass++;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if (busy !== 1'b0) $display("FAIL idle_after_reset: busy=%b, required 0", busy);
        else n_pass++;
        exp_ld = '0;
    endtask

    task automatic test_lw();
        mem_model[8'h00] = 8'h78; mem_model[8'h01] = 8'h56;
        mem_model[8'h02] = 8'h34; mem_model[8'h03] = 8'h12;
        ack_delay = 0;
        run_access(1'b1, 1'b0, 1'b0, LEN_WORD, 32'h100, 32'h0, 8, 0);
        exp_ld = 32'h1234_5678;
        n_total++;
        if (r_lat !== 5) $display("FAIL lw_latency: done at cycle %0d, required 5", r_lat);
        else n_pass++;
        n_total++;
        if (r_done !== 1 || r_err !== 0) $display("FAIL lw_done: done=%0d error=%0d, required 1/0", r_done, r_err);
        else n_pass++;
        n_total++;
        if (r_req !== 4) $display("FAIL lw_req_cycles: got %0d, required 4", r_req);
        else n_pass++;
        n_total++;
        if (acc_log.size() != 4) $display("FAIL lw_beats: got %0d, required 4", acc_log.size());
        else n_pass++;
        for (int k = 0; k < acc_log.size() && k < 4; k++) begin
            n_total++;
            if (acc_log[k].addr !== 32'h100 + 32'(k) || acc_log[k].we !== 1'b0)
                $display("FAIL lw_addr%0d: got %h we=%b, required %h we=0", k, acc_log[k].addr,
                         acc_log[k].we, 32'h100 + 32'(k));
            else n_pass++;
        end
        n_total++;
        if (r_ld_at_done !== exp_ld) $display("FAIL lw_data_with_done: got %h, required %h", r_ld_at_done, exp_ld);
        else n_pass++;
    endtask

    task automatic test_lb();
        mem_model[8'h07] = 8'h80;
        run_access(1'b1, 1'b0, 1'b0, LEN_BYTE, 32'h7, 32'h0, 5, 0);
        exp_ld = 32'hFFFF_FF80;
        n_total++;
        if (r_lat !== 2 || loadData !== exp_ld)
            $display("FAIL lb_signed: lat=%0d data=%h, required lat=2 data=%h", r_lat, loadData, exp_ld);
        else n_pass++;
        run_access(1'b1, 1'b0, 1'b1, LEN_BYTE, 32'h7, 32'h0, 5, 0);
        exp_ld = 32'h0000_0080;
        n_total++;
        if (r_lat !== 2 || loadData !== exp_ld)
            $display("FAIL lbu: lat=%0d data=%h, required lat=2 data=%h", r_lat, loadData, exp_ld);
        else n_pass++;
    endtask

    task automatic test_sh_delayed();
        ack_delay = 3;
        run_access(1'b0, 1'b1, 1'b0, LEN_HALF, 32'h22, 32'hAABB_CCDD, 14, 0);
        ack_delay = 0;
        n_total++;
        if (r_lat !== 9 || r_done !== 1)
            $display("FAIL sh_done: lat=%0d count=%0d, required lat=9 count=1", r_lat, r_done);
        else n_pass++;
        n_total++;
        if (r_req !== 8) $display("FAIL sh_req_cycles: got %0d, required 8", r_req);
        else n_pass++;
        n_total++;
        if (acc_log.size() != 2) $display("FAIL sh_beats: got %0d, required 2", acc_log.size());
        else n_pass++;
        if (acc_log.size() == 2) begin
            n_total++;
            if (acc_log[0] !== {32'h22, 1'b1, 8'hDD} || acc_log[1] !== {32'h23, 1'b1, 8'hCC})
                $display("FAIL sh_writes: got %h@%h %h@%h, required dd@22 cc@23", acc_log[0].data,
                         acc_log[0].addr, acc_log[1].data, acc_log[1].addr);
            else n_pass++;
        end
        n_total++;
        if (loadData !== exp_ld) $display("FAIL sh_loaddata_kept: got %h, required %h", loadData, exp_ld);
        else n_pass++;
    endtask

    task automatic test_errors();
        err_case_t cases[5];
        cases[0] = '{1'b1, 1'b0, 2'd3, 32'h102, "lw_misaligned"};
        cases[1] = '{1'b1, 1'b0, 2'd2, 32'h100, "len2"};
        cases[2] = '{1'b1, 1'b1, 2'd0, 32'h100, "load_and_store"};
        cases[3] = '{1'b1, 1'b0, 2'd1, 32'h101, "lh_odd"};
        cases[4] = '{1'b0, 1'b0, 2'd0, 32'h100, "neither"};
        foreach (cases[i]) begin
            run_access(cases[i].ld, cases[i].st, 1'b0, cases[i].len, cases[i].a, 32'h5555_5555, 4, 0);
            n_total++;
            if (r_lat !== 1 || r_done !== 1 || r_err !== 1 || r_err_cd !== 1)
                $display("FAIL err_%s: lat=%0d done=%0d error=%0d, required lat=1 done=1 error=1",
                         cases[i].name, r_lat, r_done, r_err);
            else n_pass++;
            n_total++;
            if (r_req !== 0 || acc_log.size() != 0 || loadData !== exp_ld)
                $display("FAIL err_%s_side: req=%0d beats=%0d data=%h, required 0/0/%h",
                         cases[i].name, r_req, acc_log.size(), loadData, exp_ld);
            else n_pass++;
        end
    endtask

    task automatic test_reset_abort();
        int found;
        int seen_done;
        ack_delay = 2;
        @(posedge clk);
        #2;
        acc_log.delete();
        load = 1'b0; store = 1'b1; loadUnsigned = 1'b0; memLength = 2'd3;
        address = 32'h40; storeData = 32'h1122_3344; start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            @(negedge clk);
            if (mif.mem_req === 1'b1 && mif.mem_addr === 32'h41) found = 1;
        end
        n_total++;
        if (found == 0) $display("FAIL abort_reach_byte1: second byte not seen, required within 20 cycles");
        else n_pass++;
        #2;
        reset_n = 1'b0;
        #1;
        n_total++;
        if (mif.mem_req !== 1'b0 || busy !== 1'b0)
            $display("FAIL abort_async: req=%b busy=%b, required 0/0", mif.mem_req, busy);
        else n_pass++;
        seen_done = 0;
        repeat (2) begin
            @(negedge clk);
            if (done !== 1'b0) seen_done++;
        end
        reset_n = 1'b1;
        exp_ld = '0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) seen_done++;
        end
        ack_delay = 0;
        n_total++;
        if (seen_done !== 0 || busy !== 1'b0 || loadData !== exp_ld)
            $display("FAIL abort_quiet: done_cycles=%0d busy=%b data=%h, required 0/0/%h",
                     seen_done, busy, loadData, exp_ld);
        else n_pass++;
        mem_model[8'h50] = 8'hC3;
        run_access(1'b1, 1'b0, 1'b0, LEN_BYTE, 32'h50, 32'h0, 5, 0);
        exp_ld = 32'hFFFF_FFC3;
        n_total++;
        if (r_lat !== 2 || r_done !== 1 || loadData !== exp_ld)
            $display("FAIL abort_then_lb: lat=%0d done=%0d data=%h, required 2/1/%h",
                     r_lat, r_done, loadData, exp_ld);
        else n_pass++;
    endtask

    task automatic test_ignored();
        int cnt_busy;
        int cnt_done;
        cnt_busy = 0;
        cnt_done = 0;
        acc_log.delete();
        stray_ack = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (busy !== 1'b0) cnt_busy++;
            if (done !== 1'b0) cnt_done++;
        end
        stray_ack = 1'b0;
        n_total++;
        if (cnt_busy !== 0 || cnt_done !== 0 || loadData !== exp_ld)
            $display("FAIL stray_ack_idle: busy_cycles=%0d done_cycles=%0d data=%h, required 0/0/%h",
                     cnt_busy, cnt_done, loadData, exp_ld);
        else n_pass++;
        mem_model[8'h00] = 8'h78; mem_model[8'h01] = 8'h56;
        mem_model[8'h02] = 8'h34; mem_model[8'h03] = 8'h12;
        run_access(1'b1, 1'b0, 1'b0, LEN_WORD, 32'h100, 32'h0, 12, 2);
        exp_ld = 32'h1234_5678;
        n_total++;
        if (r_done !== 1 || r_req !== 4 || r_lat !== 5 || loadData !== exp_ld)
            $display("FAIL start_while_busy: done=%0d req=%0d lat=%0d data=%h, required 1/4/5/%h",
                     r_done, r_req, r_lat, loadData, exp_ld);
        else n_pass++;
    endtask

    task automatic test_random();
        logic        ld, st, uns;
        logic [1:0]  len;
        logic [31:0] a, sd, exp_val;
        int          kind, n, bad_beats;
        bit          illegal;
        rand_delay = 1'b1;
        for (int k = 0; k < 256; k++) mem_model[k] = 8'($urandom);
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 5));
            ld   = (kind <= 2) || (kind == 5 && $urandom_range(0, 1) == 1);
            st   = (kind == 3) || (kind == 4) || (kind == 5 && ld);
            uns  = 1'($urandom);
            len  = 2'($urandom_range(0, 3));
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
            sd   = $urandom;
            n    = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
            illegal = (ld == st) || (len == 2'd2) || (len == 2'd1 && a % 2 != 0) ||
                      (len == 2'd3 && a % 4 != 0);
            exp_val = ref_load(a, len, uns);
            run_access(ld, st, uns, len, a, sd, 20, 0);
            if (illegal) begin
                n_total++;
                if (r_done !== 1 || r_err !== 1 || r_lat !== 1 || acc_log.size() != 0 || loadData !== exp_ld)
                    $display("FAIL rand%0d_reject: done=%0d err=%0d lat=%0d beats=%0d data=%h, required 1/1/1/0/%h",
                             it, r_done, r_err, r_lat, acc_log.size(), loadData, exp_ld);
                else n_pass++;
            end else begin
                bad_beats = 0;
                if (acc_log.size() != n) bad_beats = 99;
                else
                    for (int k = 0; k < n; k++)
                        if (acc_log[k].addr !== a + 32'(k) || acc_log[k].we !== st ||
                            (st && acc_log[k].data !== 8'(sd >> (8 * k))))
                            bad_beats++;
                n_total++;
                if (r_done !== 1 || r_err !== 0 || bad_beats != 0)
                    $display("FAIL rand%0d_xfer: done=%0d err=%0d bad_beats=%0d, required 1/0/0",
                             it, r_done, r_err, bad_beats);
                else n_pass++;
                if (ld) exp_ld = exp_val;
                n_total++;
                if (loadData !== exp_ld)
                    $display("FAIL rand%0d_loaddata: got %h, required %h", it, loadData, exp_ld);
                else n_pass++;
            end
        end
        rand_delay = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb();
        test_sh_delayed();
        test_errors();
        test_reset_abort();
        test_ignored();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
